// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM encoding,
// default memory geometry and the alignment rule.
package dm_pkg;

    localparam int DM_WORDS_DEF = 1024;
    localparam int IDX_W_DEF    = 10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Illegal size codes count as misaligned so one check covers both.
    function automatic logic bad_align(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = |lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// CPU request/response signals plus the word-wide DM port, bundled for the access unit.
// Handshake: req is sampled only while the unit is idle (busy=0); done pulses for one
// cycle with err and rdata valid; a req seen while busy is dropped, never queued.
interface dm_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_memwrite;
    logic        dm_memread;
    logic [31:0] dm_rdata;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, dm_rdata,
        output busy, done, err, rdata, dm_addr, dm_wdata, dm_memwrite, dm_memread
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, dm_rdata,
        input  busy, done, err, rdata, dm_addr, dm_wdata, dm_memwrite, dm_memread
    );
endinterface

// File: rtl/dm_lane_unit.sv
// Combinational byte-lane logic: extract and extend a load lane, or merge store
// data into the old word for read-modify-write.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sign_ext_i,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = old_i[{lane_i, 3'b000} +: 8];
        half_v  = old_i[{lane_i[1], 4'b0000} +: 16];
        load_o  = old_i;
        merge_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{24{sign_ext_i & byte_v[7]}}, byte_v};
                merge_o = old_i;
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o  = {{16{sign_ext_i & half_v[15]}}, half_v};
                merge_o = old_i;
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dm_access_unit.sv
// Load/store initiator: checks each byte-addressed request and turns it into word
// reads/writes on DM, using read-modify-write for byte and halfword stores.
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    dm_access_unit_if.slave  bus,
    output state_t           dbg_state_o
);
    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] load_word, merge_word;
    logic        req_bad;

    dm_lane_unit u_lane (
        .size_i     (size_q),
        .lane_i     (lane_q),
        .sign_ext_i (sext_q),
        .old_i      (bus.dm_rdata),
        .wdata_i    (wdata_q),
        .load_o     (load_word),
        .merge_o    (merge_word)
    );

    assign req_bad = bad_align(bus.size, bus.addr[1:0]) ||
                     (bus.addr[31:2] >= 30'(DM_WORDS));

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        sext_d     = sext_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    sext_d  = bus.sign_ext;
                    lane_d  = bus.addr[1:0];
                    wdata_d = bus.wdata;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = ST_DONE;
                    end else begin
                        // DM address is registered here so nothing on the DM side depends on req.
                        dm_addr_d = 32'(bus.addr[IDX_W+1:2]);
                        if (bus.we && bus.size == SZ_WORD) begin
                            dm_wdata_d = bus.wdata;
                            state_d    = ST_WR;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    dm_wdata_d = merge_word;
                    state_d    = ST_WR;
                end else begin
                    rdata_d = load_word;
                    state_d = ST_DONE;
                end
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            sext_q     <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            dm_addr_q  <= 32'h0;
            dm_wdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.err         = (state_q == ST_DONE) && err_q;
    assign bus.dm_memread  = (state_q == ST_RD);
    assign bus.dm_memwrite = (state_q == ST_WR);
    assign bus.rdata       = rdata_q;
    assign bus.dm_addr     = dm_addr_q;
    assign bus.dm_wdata    = dm_wdata_q;
    assign dbg_state_o     = state_q;
endmodule
